// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clock-enable divider bank.
// half_ceil works at a fixed 64-bit width so any counter width up to 64 fits.
package clk_div_pkg;

  localparam int          DEF_CNT_W     = 32;
  localparam int unsigned DEF_RESET_DIV = 1000;
  localparam int          HC_W          = 64;

  // ceil(n/2) without the overflow that (n+1)>>1 would hit at the top of the range
  function automatic logic [HC_W-1:0] half_ceil(input logic [HC_W-1:0] n);
    return (n >> 1) + HC_W'(n[0]);
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, active/pending ratio, registered tick and square wave.
// A new ratio only takes over at a period boundary, on sync, or while the channel is idle.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int          CNT_W     = DEF_CNT_W,
  parameter int unsigned RESET_DIV = DEF_RESET_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             load,
  input  logic [CNT_W-1:0] div_val,
  output logic             tick,
  output logic             div_out,
  output logic             pend
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(RESET_DIV);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] n_act;
  logic [CNT_W-1:0] n_pend;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] n_act_nxt;
  logic [CNT_W:0]   half_n;
  logic             active;
  logic             tc;
  logic             wrap;
  logic             pend_nxt;
  logic             tick_nxt;
  logic             div_nxt;

  assign active = (n_act != '0);
  assign tc     = active && (cnt == n_act - ONE);
  assign half_n = (CNT_W+1)'(half_ceil(HC_W'(n_act)));

  // An idle channel (N=0) behaves as if it wraps every edge, so a loaded ratio starts at once.
  assign wrap = sync || !active || (en && tc);

  always_comb begin
    cnt_nxt   = cnt;
    n_act_nxt = n_act;
    pend_nxt  = pend;
    if (wrap) begin
      cnt_nxt  = '0;
      pend_nxt = 1'b0;
      if (load) begin
        n_act_nxt = div_val;
      end else if (pend) begin
        n_act_nxt = n_pend;
      end
    end else begin
      if (en) begin
        cnt_nxt = cnt + ONE;
      end
      if (load) begin
        pend_nxt = 1'b1;
      end
    end
    tick_nxt = en && tc && !sync;
    div_nxt  = en ? (active && ({1'b0, cnt} < half_n)) : div_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      n_act   <= RST_DIV;
      n_pend  <= RST_DIV;
      pend    <= 1'b0;
      tick    <= 1'b0;
      div_out <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      n_act   <= n_act_nxt;
      pend    <= pend_nxt;
      tick    <= tick_nxt;
      div_out <= div_nxt;
      if (load) begin
        n_pend <= div_val;
      end
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock-enable dividers for the timebase.
// Control strobes fan out to every channel; each channel gets its own ratio slice.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int          N_CH      = 2,
  parameter int          CNT_W     = DEF_CNT_W,
  parameter int unsigned RESET_DIV = DEF_RESET_DIV
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  sync,
  input  logic                  load,
  input  logic [N_CH*CNT_W-1:0] div_val,
  output logic [N_CH-1:0]       tick,
  output logic [N_CH-1:0]       div_out,
  output logic [N_CH-1:0]       pend
);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    clk_div_ch #(
      .CNT_W     (CNT_W),
      .RESET_DIV (RESET_DIV)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .sync    (sync),
      .load    (load),
      .div_val (div_val[k*CNT_W +: CNT_W]),
      .tick    (tick[k]),
      .div_out (div_out[k]),
      .pend    (pend[k])
    );
  end

endmodule
